// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Pops WIDTH-bit entries from a first-word-fall-through FIFO and packs RATIO
// consecutive entries into one wide word on a valid/ready stream. A partial
// word leaves on an explicit flush request or after TIMEOUT idle cycles.
//
// Ports:
//   i_CLK         clock, rising edge
//   i_RESET       synchronous active-high reset
//   i_FIFO_DATA   head-of-FIFO data (valid while i_FIFO_EMPTY=0)
//   i_FIFO_EMPTY  FIFO empty flag
//   o_FIFO_RD_EN  pop strobe (combinational)
//   i_FLUSH       single-cycle request to emit the partial word
//   o_DATA        packed word, lane 0 = oldest entry in bits [WIDTH-1:0]
//   o_KEEP        per-lane valid bits, contiguous from lane 0
//   o_LAST        word was closed by a flush
//   o_VALID       output word valid
//   i_READY       downstream accept
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET,
  input  logic [WIDTH-1:0]       i_FIFO_DATA,
  input  logic                   i_FIFO_EMPTY,
  output logic                   o_FIFO_RD_EN,
  input  logic                   i_FLUSH,
  output logic [WIDTH*RATIO-1:0] o_DATA,
  output logic [RATIO-1:0]       o_KEEP,
  output logic                   o_LAST,
  output logic                   o_VALID,
  input  logic                   i_READY
);

  localparam int CNT_W  = $clog2(RATIO + 1);
  // Keep the idle counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RATIO);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  logic [WIDTH-1:0]       lane_reg [RATIO];
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDLE_W-1:0]      idle_reg, idle_next;
  logic                   flush_pending_reg, flush_pending_next;
  logic [WIDTH*RATIO-1:0] data_reg;
  logic [RATIO-1:0]       keep_reg;
  logic                   last_reg, valid_reg;

  logic                   acc_any, acc_full, out_free, expired, xfer, pop;
  logic [CNT_W-1:0]       wr_idx;
  logic [WIDTH*RATIO-1:0] packed_word;
  logic [RATIO-1:0]       keep_word;

  assign acc_any  = (cnt_reg != '0);
  assign acc_full = (cnt_reg == CNT_FULL);
  assign out_free = !valid_reg || i_READY;
  assign expired  = (TIMEOUT != 0) && (idle_reg == IDLE_MAX);

  // Any transfer with flush_pending set is attributed to the flush.
  assign xfer = out_free && (acc_full || (acc_any && (flush_pending_reg || expired)));

  // A full accumulator can still pop when it is emptied in the same cycle.
  assign pop = !i_RESET && !i_FIFO_EMPTY && !flush_pending_reg && (!acc_full || xfer);
  assign o_FIFO_RD_EN = pop;

  // On a transfer cycle the concurrent pop starts the next word at lane 0.
  assign wr_idx = xfer ? '0 : cnt_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign keep_word[gi] = (CNT_W'(gi) < cnt_reg);
    assign packed_word[gi*WIDTH +: WIDTH] = keep_word[gi] ? lane_reg[gi] : '0;

    // Lane contents are qualified by cnt/keep, so they need no reset.
    always_ff @(posedge i_CLK) begin
      if (pop && (wr_idx == CNT_W'(gi))) begin
        lane_reg[gi] <= i_FIFO_DATA;
      end
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (xfer) begin
      cnt_next = '0;
    end
    if (pop) begin
      cnt_next = wr_idx + CNT_W'(1);
    end
  end

  always_comb begin
    idle_next = idle_reg;
    if (pop || !acc_any) begin
      idle_next = '0;
    end else if (idle_reg != IDLE_MAX) begin
      idle_next = idle_reg + IDLE_W'(1);
    end
  end

  always_comb begin
    flush_pending_next = flush_pending_reg;
    if (flush_pending_reg) begin
      // Nothing to emit means the request is simply dropped.
      if (xfer || !acc_any) begin
        flush_pending_next = 1'b0;
      end
    end else if (i_FLUSH) begin
      flush_pending_next = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cnt_reg           <= '0;
      idle_reg          <= '0;
      flush_pending_reg <= 1'b0;
      data_reg          <= '0;
      keep_reg          <= '0;
      last_reg          <= 1'b0;
      valid_reg         <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      idle_reg          <= idle_next;
      flush_pending_reg <= flush_pending_next;
      if (xfer) begin
        data_reg  <= packed_word;
        keep_reg  <= keep_word;
        last_reg  <= flush_pending_reg;
        valid_reg <= 1'b1;
      end else if (i_READY) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_DATA  = data_reg;
  assign o_KEEP  = keep_reg;
  assign o_LAST  = last_reg;
  assign o_VALID = valid_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based reference model predicts pops
// and output words; a separate monitor checks every accepted word against
// the expected-word queue.
`timescale 1ns/1ps
module tb_fifo_rd_packer;

  localparam int WIDTH   = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        i_RESET, i_FIFO_EMPTY, i_FLUSH, i_READY;
  logic [7:0]  i_FIFO_DATA;
  logic        o_FIFO_RD_EN, o_LAST, o_VALID;
  logic [31:0] o_DATA;
  logic [3:0]  o_KEEP;

  always #5 clk = ~clk;

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .i_CLK(clk), .i_RESET(i_RESET), .i_FIFO_DATA(i_FIFO_DATA),
    .i_FIFO_EMPTY(i_FIFO_EMPTY), .o_FIFO_RD_EN(o_FIFO_RD_EN), .i_FLUSH(i_FLUSH),
    .o_DATA(o_DATA), .o_KEEP(o_KEEP), .o_LAST(o_LAST), .o_VALID(o_VALID),
    .i_READY(i_READY)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];   // contents of the FIFO feeding the DUT
  logic [7:0] acc_q[$];    // model: entries gathered for the next word
  word_t      exp_q[$];    // scoreboard: words the DUT must emit, in order
  word_t      got_q[$];    // words accepted downstream, for directed checks
  bit         m_pend, m_valid, prev_rst;
  int         m_idle;
  bit         rst_v, rdy_v, fl_v, force_empty;

  task automatic model_step();
    int    n;
    bit    free_w, expd, dox, rd;
    word_t w;
    n = acc_q.size();
    if (prev_rst) begin
      checks++;
      if (o_VALID !== 1'b0 || o_DATA !== 32'h0 || o_KEEP !== 4'h0 || o_LAST !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b data=%h keep=%h last=%b required all 0",
                 o_VALID, o_DATA, o_KEEP, o_LAST);
      end
    end
    checks++;
    if (o_VALID !== m_valid) begin
      errors++;
      $display("FAIL valid: got %b required %b at %0t", o_VALID, m_valid, $time);
    end
    free_w = !m_valid || i_READY;
    expd   = (TIMEOUT != 0) && (m_idle == TIMEOUT);
    dox    = free_w && (n > 0) && (n == RATIO || m_pend || expd);
    rd     = !i_RESET && !i_FIFO_EMPTY && !m_pend && (n < RATIO || dox);
    checks++;
    if (o_FIFO_RD_EN !== rd) begin
      errors++;
      $display("FAIL rd_en: got %b required %b at %0t", o_FIFO_RD_EN, rd, $time);
    end
    prev_rst = i_RESET;
    if (i_RESET) begin
      acc_q.delete();
      exp_q.delete();
      m_pend = 0; m_valid = 0; m_idle = 0;
      return;
    end
    if (dox) begin
      w.data = 32'h0;
      for (int i = 0; i < n; i++) w.data[8*i +: 8] = acc_q[i];
      w.keep = 4'((1 << n) - 1);
      w.last = m_pend;
      exp_q.push_back(w);
      acc_q.delete();
      m_valid = 1;
    end else if (i_READY) begin
      m_valid = 0;
    end
    if (m_pend) begin
      if (dox || n == 0) m_pend = 0;
    end else if (i_FLUSH) begin
      m_pend = 1;
    end
    if (rd || n == 0) m_idle = 0;
    else if (m_idle < TIMEOUT) m_idle++;
    if (rd) acc_q.push_back(fifo_q.pop_front());
  endtask

  task automatic cycle();
    @(negedge clk);
    i_RESET      = rst_v;
    i_READY      = rdy_v;
    i_FLUSH      = fl_v;
    i_FIFO_EMPTY = force_empty || (fifo_q.size() == 0);
    i_FIFO_DATA  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    #1;
    model_step();
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    checks++;
    if (got_q.size() <= idx) begin
      errors++;
      $display("FAIL %s: got %0d words required word %0d", name, got_q.size(), idx);
    end else if (got_q[idx].data !== d || got_q[idx].keep !== k || got_q[idx].last !== l) begin
      errors++;
      $display("FAIL %s: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
               name, got_q[idx].data, got_q[idx].keep, got_q[idx].last, d, k, l);
    end
  endtask

  // Monitor: compares every accepted word with the head of the scoreboard.
  initial begin : monitor
    word_t held, act, e;
    bit    holding;
    holding = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!i_RESET && o_VALID) begin
        act.data = o_DATA; act.keep = o_KEEP; act.last = o_LAST;
        if (holding) begin
          checks++;
          if (act !== held) begin
            errors++;
            $display("FAIL stall_hold: got %h/%h/%b required %h/%h/%b",
                     act.data, act.keep, act.last, held.data, held.keep, held.last);
          end
        end
        if (i_READY) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL word: got %h/%h/%b required no word", act.data, act.keep, act.last);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              errors++;
              $display("FAIL word: got %h/%h/%b required %h/%h/%b",
                       act.data, act.keep, act.last, e.data, e.keep, e.last);
            end
          end
          $display("word data=%h keep=%h last=%b", act.data, act.keep, act.last);
          got_q.push_back(act);
          holding = 0;
        end else begin
          held = act;
          holding = 1;
        end
      end else begin
        holding = 0;
      end
    end
  end

  initial begin : stimulus
    int nwords;
    i_RESET = 1; i_READY = 0; i_FLUSH = 0; i_FIFO_EMPTY = 1; i_FIFO_DATA = 0;
    rst_v = 1; rdy_v = 0; fl_v = 0; force_empty = 0;
    m_pend = 0; m_valid = 0; m_idle = 0; prev_rst = 0;

    // Reset with a loaded FIFO: no pop may happen.
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h1A + i));
    repeat (2) cycle();
    rst_v = 0;

    // Streaming.
    rdy_v = 1;
    repeat (15) cycle();
    check_word("stream0", 0, 32'h1D1C1B1A, 4'hF, 1'b0);
    check_word("stream1", 1, 32'h21201F1E, 4'hF, 1'b0);
    got_q.delete();

    // Backpressure.
    rdy_v = 0;
    for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h30 + i));
    repeat (10) cycle();
    rdy_v = 1;
    repeat (20) cycle();
    check_word("bp0", 0, 32'h33323130, 4'hF, 1'b0);
    check_word("bp1", 1, 32'h37363534, 4'hF, 1'b0);
    check_word("bp2", 2, 32'h3B3A3938, 4'hF, 1'b0);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL bp_count: got %0d words required 3", got_q.size());
    end
    got_q.delete();

    // Flush of a partial word, then a flush with nothing accumulated.
    fifo_q.push_back(8'h65); fifo_q.push_back(8'h66); fifo_q.push_back(8'h67);
    repeat (6) cycle();
    fl_v = 1; cycle(); fl_v = 0;
    repeat (5) cycle();
    check_word("flush", 0, 32'h00676665, 4'b0111, 1'b1);
    nwords = got_q.size();
    fl_v = 1; cycle(); fl_v = 0;
    repeat (6) cycle();
    checks++;
    if (got_q.size() != nwords) begin
      errors++;
      $display("FAIL empty_flush: got %0d words required %0d", got_q.size(), nwords);
    end
    got_q.delete();

    // Timeout of a single entry.
    fifo_q.push_back(8'h01);
    repeat (22) cycle();
    check_word("timeout", 0, 32'h00000001, 4'b0001, 1'b0);
    got_q.delete();

    // Empty flag held, then a continuous stream with toggling ready.
    force_empty = 1;
    for (int i = 0; i < 40; i++) fifo_q.push_back(8'($urandom));
    repeat (20) cycle();
    force_empty = 0;
    for (int i = 0; i < 60; i++) begin
      rdy_v = ~rdy_v;
      cycle();
    end

    // Randomized traffic with flushes, stalls, empty gaps and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
      rdy_v       = ($urandom_range(0, 3) != 0);
      fl_v        = ($urandom_range(0, 19) == 0);
      force_empty = ($urandom_range(0, 7) == 0);
      rst_v       = ($urandom_range(0, 299) == 0);
      cycle();
    end

    // Drain.
    rst_v = 0; fl_v = 0; force_empty = 0; rdy_v = 1;
    for (int i = 0; i < 300; i++) begin
      if (fifo_q.size() == 0 && acc_q.size() == 0 && exp_q.size() == 0 && !m_valid) break;
      cycle();
    end
    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 0 || acc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
